alu_issue_ctrl: RTL and testbench

//  Initiator side of the 32-bit ALU interface (first/second/op -> result/zero).

---
 rtl/alu_issue_ctrl_pkg.sv | 35 +++
 rtl/alu_issue_ctrl_if.sv | 35 +++
 rtl/alu_32bit.sv | 24 ++
 rtl/alu_issue_ctrl_op_decode.sv | 36 +++
 rtl/alu_issue_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 268 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALU op codes, ALUOp/funct codes, FSM states.
package alu_issue_ctrl_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StMul,
    StResp
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    logic       is_mul;
    logic       err;
  } dec_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decode-side request/response handshake plus the operand/result bus to the external ALU.
interface alu_issue_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_aluop;
  logic [5:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [31:0] rsp_hi;
  logic        rsp_zero;
  logic        rsp_err;
  logic [31:0] alu_first;
  logic [31:0] alu_second;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;

  // master: the issue controller
  modport master (
    input  req_valid, req_aluop, req_funct, req_a, req_b, rsp_ready, alu_result, alu_zero,
    output req_ready, rsp_valid, rsp_result, rsp_hi, rsp_zero, rsp_err,
    output alu_first, alu_second, alu_op
  );

  modport slave (
    output req_valid, req_aluop, req_funct, req_a, req_b, rsp_ready, alu_result, alu_zero,
    input  req_ready, rsp_valid, rsp_result, rsp_hi, rsp_zero, rsp_err,
    input  alu_first, alu_second, alu_op
  );

endinterface

// File: rtl/alu_32bit.sv
// Combinational 32-bit ALU: and/or/add/sub/slt with zero flag.
module alu_32bit (
  input  logic [31:0] first,
  input  logic [31:0] second,
  input  logic [2:0]  op,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (op)
      3'b000:  result = first & second;
      3'b001:  result = first | second;
      3'b010:  result = first + second;
      3'b110:  result = first - second;
      3'b111:  result = {31'd0, $signed(first) < $signed(second)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_issue_ctrl_op_decode.sv
// Combinational ALUOp/funct decode into the 3-bit ALU op, multiply select and error flag.
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '{op: ALU_ADD, is_mul: 1'b0, err: 1'b0};
    unique case (aluop)
      ALUOP_ADD:   dec.op = ALU_ADD;
      ALUOP_SUB:   dec.op = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD:   dec.op = ALU_ADD;
          FUNCT_SUB:   dec.op = ALU_SUB;
          FUNCT_AND:   dec.op = ALU_AND;
          FUNCT_OR:    dec.op = ALU_OR;
          FUNCT_SLT:   dec.op = ALU_SLT;
          FUNCT_MULTU: begin
            if (MUL_EN) dec.is_mul = 1'b1;
            else        dec.err    = 1'b1;
          end
          default:     dec.err = 1'b1;
        endcase
      end
      ALUOP_RSVD:  dec.err = 1'b1;
      default:     dec.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues decoded requests to an external combinational ALU and returns registered results;
// MULTU is sequenced as shift-add passes through the same ALU adder.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter bit          MUL_EN   = 1'b1,
  parameter int unsigned MUL_ITER = 32
) (
  input logic             clk,
  input logic             rst_n,
  alu_issue_ctrl_if.master bus
);

  localparam int unsigned CntW = $clog2(MUL_ITER);
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_ITER - 1);

  state_e            state_q, state_d;
  logic [31:0]       first_q, first_d, second_q, second_d;
  logic [31:0]       result_q, result_d, hi_q, hi_d;
  logic [2:0]        op_q, op_d;
  logic              zero_q, zero_d, err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  dec_t              dec;
  logic              carry;
  logic [63:0]       shifted;

  alu_op_decode #(
    .MUL_EN(MUL_EN)
  ) u_dec (
    .aluop(bus.req_aluop),
    .funct(bus.req_funct),
    .dec  (dec)
  );

  // Carry out of hi + mcand, recovered from the operand and sum MSBs.
  assign carry = (first_q[31] & second_q[31]) |
                 ((first_q[31] | second_q[31]) & ~bus.alu_result[31]);

  // During MULTU result_q holds LO and second_q holds the multiplicand.
  always_comb begin
    shifted = {1'b0, hi_q, result_q[31:1]};
    if (result_q[0]) shifted = {carry, bus.alu_result, result_q[31:1]};
  end

  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    second_d = second_q;
    op_d     = op_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          hi_d     = '0;
          result_d = '0;
          zero_d   = 1'b0;
          err_d    = dec.err;
          cnt_d    = '0;
          if (dec.err) begin
            state_d = StResp;
          end else if (dec.is_mul) begin
            first_d  = '0;
            second_d = bus.req_a;
            op_d     = ALU_ADD;
            result_d = bus.req_b;
            state_d  = StMul;
          end else begin
            first_d  = bus.req_a;
            second_d = bus.req_b;
            op_d     = dec.op;
            state_d  = StExec;
          end
        end
      end
      StExec: begin
        result_d = bus.alu_result;
        zero_d   = bus.alu_zero;
        state_d  = StResp;
      end
      StMul: begin
        hi_d     = shifted[63:32];
        result_d = shifted[31:0];
        first_d  = shifted[63:32];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          zero_d  = (shifted == '0);
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      first_q  <= '0;
      second_q <= '0;
      op_q     <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      second_q <= second_d;
      op_q     <= op_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_result = result_q;
  assign bus.rsp_hi     = hi_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = err_q;
  assign bus.alu_first  = first_q;
  assign bus.alu_second = second_q;
  assign bus.alu_op     = op_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl driving a real alu_32bit on the ALU bus.
module tb_alu_issue_ctrl;

  typedef struct {
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl_if ifc ();

  alu_issue_ctrl #(
    .MUL_EN  (1'b1),
    .MUL_ITER(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  alu_32bit u_alu (
    .first (ifc.alu_first),
    .second(ifc.alu_second),
    .op    (ifc.alu_op),
    .result(ifc.alu_result),
    .zero  (ifc.alu_zero)
  );

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_tmo = 0;
  int   seen_tmo = 0;
  bit   chk_reset = 1'b0;
  bit   hold_rsp = 1'b0;

  task automatic cmp(input string name, input logic [95:0] got, input logic [95:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: plain arithmetic from the instruction semantics.
  function automatic exp_t model(input logic [1:0] aluop, input logic [5:0] funct,
                                 input logic [31:0] a, input logic [31:0] b, input int acc);
    exp_t        e;
    logic [63:0] p;
    bit          mul;
    e.result = '0;
    e.hi     = '0;
    e.err    = 1'b0;
    e.lat    = 2;
    e.acc    = acc;
    p        = '0;
    mul      = 1'b0;
    case (aluop)
      2'd0: e.result = a + b;
      2'd1: e.result = a - b;
      2'd2: begin
        case (funct)
          6'h20: e.result = a + b;
          6'h22: e.result = a - b;
          6'h24: e.result = a & b;
          6'h25: e.result = a | b;
          6'h2a: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h19: begin
            p        = {32'd0, a} * {32'd0, b};
            mul      = 1'b1;
            e.result = p[31:0];
            e.hi     = p[63:32];
            e.lat    = 33;
          end
          default: e.err = 1'b1;
        endcase
      end
      default: e.err = 1'b1;
    endcase
    if (e.err) begin
      e.result = '0;
      e.lat    = 1;
    end
    e.zero = e.err ? 1'b0 : (mul ? (p == 64'd0) : (e.result == 32'd0));
    return e;
  endfunction

  // Response consumer: random backpressure unless a hold is requested.
  initial begin
    ifc.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ifc.rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  // Monitor: pops expectations on each new response, then checks it stays stable while held.
  initial begin : monitor
    exp_t        e;
    logic [65:0] cap;
    bit          holding;
    holding = 1'b0;
    cap     = '0;
    forever begin
      @(negedge clk);
      if (n_tmo != seen_tmo) begin
        cmp("handshake_timeout", 96'(n_tmo), 96'(seen_tmo));
        seen_tmo = n_tmo;
      end
      if (chk_reset) begin
        cmp("reset_req_ready", 96'(ifc.req_ready), 96'd1);
        cmp("reset_rsp_valid", 96'(ifc.rsp_valid), 96'd0);
        cmp("reset_rsp_out", 96'({ifc.rsp_result, ifc.rsp_hi, ifc.rsp_zero, ifc.rsp_err}), 96'd0);
        cmp("reset_alu_first", 96'(ifc.alu_first), 96'd0);
        cmp("reset_alu_second", 96'(ifc.alu_second), 96'd0);
        cmp("reset_alu_op", 96'(ifc.alu_op), 96'd0);
      end
      if (!rst_n) begin
        holding = 1'b0;
      end else if (ifc.rsp_valid) begin
        if (!holding) begin
          if (exp_q.size() == 0) begin
            cmp("unexpected_rsp", 96'(ifc.rsp_valid), 96'd0);
          end else begin
            e = exp_q.pop_front();
            cmp("rsp_result", 96'(ifc.rsp_result), 96'(e.result));
            cmp("rsp_hi", 96'(ifc.rsp_hi), 96'(e.hi));
            cmp("rsp_zero", 96'(ifc.rsp_zero), 96'(e.zero));
            cmp("rsp_err", 96'(ifc.rsp_err), 96'(e.err));
            cmp("rsp_latency", 96'(cyc - e.acc), 96'(e.lat));
          end
          cap     = {ifc.rsp_result, ifc.rsp_hi, ifc.rsp_zero, ifc.rsp_err};
          holding = 1'b1;
        end else begin
          cmp("rsp_stable", 96'({ifc.rsp_result, ifc.rsp_hi, ifc.rsp_zero, ifc.rsp_err}),
              96'(cap));
        end
        cmp("req_ready_in_resp", 96'(ifc.req_ready), 96'd0);
        if (ifc.rsp_ready) holding = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (!ifc.req_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!ifc.req_ready) n_tmo++;
  endtask

  task automatic issue(input logic [1:0] aluop, input logic [5:0] funct,
                       input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    if (!ifc.req_ready) return;
    ifc.req_valid = 1'b1;
    ifc.req_aluop = aluop;
    ifc.req_funct = funct;
    ifc.req_a     = a;
    ifc.req_b     = b;
    exp_q.push_back(model(aluop, funct, a, b, cyc));
    n_vec++;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    ifc.req_aluop = 2'($urandom);
    ifc.req_funct = 6'($urandom);
    ifc.req_a     = $urandom;
    ifc.req_b     = $urandom;
  endtask

  function automatic logic [5:0] pick_funct();
    case ($urandom_range(6))
      0:       return 6'h20;
      1:       return 6'h22;
      2:       return 6'h24;
      3:       return 6'h25;
      4:       return 6'h2a;
      5:       return 6'h19;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial begin : stim
    int k;
    ifc.req_valid = 1'b0;
    ifc.req_aluop = '0;
    ifc.req_funct = '0;
    ifc.req_a     = '0;
    ifc.req_b     = '0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset = 1'b1;
    @(negedge clk);
    #1 chk_reset = 1'b0;
    rst_n = 1'b1;

    issue(2'b00, 6'h00, 32'd5, 32'd7);
    issue(2'b01, 6'h00, 32'h1234, 32'h1234);
    issue(2'b10, 6'h2a, 32'hFFFF_FFFF, 32'd1);
    issue(2'b10, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00);
    issue(2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b10, 6'h19, 32'd0, $urandom);

    // Error response held under backpressure for a dozen cycles.
    wait_idle();
    hold_rsp = 1'b1;
    issue(2'b10, 6'h00, $urandom, $urandom);
    repeat (12) @(posedge clk);
    hold_rsp = 1'b0;
    issue(2'b11, 6'h20, $urandom, $urandom);

    // Reset in the middle of a multiply.
    issue(2'b10, 6'h19, $urandom, $urandom);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk_reset = 1'b1;
    @(negedge clk);
    #1 chk_reset = 1'b0;
    rst_n = 1'b1;
    issue(2'b00, 6'h00, 32'd1, 32'd1);

    for (int i = 0; i < 150; i++) begin
      issue(2'($urandom_range(3) == 3 ? 3 : $urandom_range(2)), pick_funct(),
            pick_operand(), pick_operand());
    end

    k = 0;
    while ((exp_q.size() != 0 || ifc.rsp_valid) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) n_tmo++;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
